// File: rtl/multdiv_pkg.sv
// multdiv_pkg -- shared types and constants for the multdiv block.
//   state_t    : controller states (IDLE, MULT, DIV, DONE)
//   MULT_ITERS : multiply iterations (16 with MULTDIV_BOOTH4_EN, else 32)
//   DIV_ITERS  : divide iterations (always 32)
//   INT_MIN    : most negative 32-bit two's complement value
//   abs32()    : two's complement magnitude (INT_MIN maps to 0x80000000 unsigned)
// Configuration macro: MULTDIV_BOOTH4_EN selects radix-4 Booth multiply.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MULT_ITERS = 16;
`else
  localparam int MULT_ITERS = 32;
`endif
  localparam int DIV_ITERS = 32;

  localparam logic [5:0] MULT_LAST = 6'(MULT_ITERS - 1);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_ITERS - 1);

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// multdiv_if -- operand/control/result bundle between a requester and multdiv.
//   data_operandA/B : operands (two's complement), sampled with a start pulse
//   ctrl_MULT/DIV   : one-cycle start pulses (multiply wins if both high)
//   data_result     : low product word or quotient
//   data_exception  : overflow / divide error, valid with data_resultRDY
//   data_resultRDY  : one-cycle completion pulse
// Modports: master (requester side), slave (multdiv side).
interface multdiv_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_counter.sv
// multdiv_counter -- 6-bit iteration counter for the multdiv controller.
//   clock : rising-edge clock
//   reset : synchronous active-low reset (clears the count)
//   clr   : synchronous clear (a new operation starts)
//   en    : advance by one
//   last  : terminal count value for the current operation
//   tc    : high while the count equals last
// The count parks on the terminal value instead of wrapping, so a late
// enable can never alias into a fresh iteration sequence.
module multdiv_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [5:0] last,
  output logic       tc
);
  logic [5:0] count_reg;

  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != last)) begin
      count_reg <= count_reg + 6'd1;
    end
  end

  assign tc = (count_reg == last);
endmodule

// File: rtl/multdiv.sv
// multdiv -- iterative signed 32-bit multiplier / divider.
//   clock : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : multdiv_if.slave (operands, start pulses, result, exception, ready)
// Multiply: radix-2 shift-add on magnitudes (32 iterations), or radix-4 Booth
// on signed operands (16 iterations) when MULTDIV_BOOTH4_EN is defined.
// Divide: non-restoring on magnitudes, 32 iterations, quotient sign fixed at
// the end. One 65-bit register holds the product or remainder/quotient.
module multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clock,
  input  logic     reset,
  multdiv_if.slave bus
);
  state_t state_reg, state_next;

  logic start_mult, start_div, start_any, div_by_zero;
  logic cnt_clr, cnt_en, cnt_tc;
  logic [5:0] cnt_last;
  logic finish_mult, finish_div, rdy;

  logic [64:0]      acc_reg;
  logic [WIDTH-1:0] opd_reg;   // multiplicand or divisor magnitude
  logic             neg_reg;   // operand signs differ
  logic [WIDTH-1:0] result_reg;
  logic             exc_reg;

  logic [64:0] mult_step, div_step;
  logic [63:0] mult_prod;
  logic [31:0] div_q;

  assign start_mult  = bus.ctrl_MULT;
  assign start_div   = bus.ctrl_DIV & ~bus.ctrl_MULT;
  assign start_any   = start_mult | start_div;
  assign div_by_zero = start_div && (bus.data_operandB == '0);

  multdiv_counter u_counter (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (cnt_last),
    .tc    (cnt_tc)
  );

  // ---------------- controller ----------------
  always_ff @(posedge clock) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // A start always takes priority, which gives abort-and-restart for free.
  always_comb begin
    state_next = state_reg;
    if (start_mult) begin
      state_next = MULT;
    end else if (start_div) begin
      state_next = div_by_zero ? DONE : DIV;
    end else begin
      case (state_reg)
        MULT:    if (cnt_tc) state_next = DONE;
        DIV:     if (cnt_tc) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_clr     = start_any;
    cnt_en      = 1'b0;
    cnt_last    = DIV_LAST;
    finish_mult = 1'b0;
    finish_div  = 1'b0;
    rdy         = 1'b0;
    case (state_reg)
      MULT: begin
        cnt_en      = ~start_any;
        cnt_last    = MULT_LAST;
        finish_mult = cnt_tc & ~start_any;
      end
      DIV: begin
        cnt_en     = ~start_any;
        finish_div = cnt_tc & ~start_any;
      end
      DONE:    rdy = 1'b1;
      default: ;
    endcase
  end

  // ---------------- multiply step ----------------
`ifdef MULTDIV_BOOTH4_EN
  // acc = {hi[31:0], multiplier/low product[31:0], booth guard bit}.
  // The running partial stays within 32 signed bits after the shift, so only
  // the pre-shift sum needs the 34-bit width.
  logic [33:0] a_ext, a_ext2, booth_addend, mul_sum;
  assign a_ext  = {{2{opd_reg[31]}}, opd_reg};
  assign a_ext2 = a_ext << 1;

  always_comb begin
    case (acc_reg[2:0])
      3'b001, 3'b010: booth_addend = a_ext;
      3'b011:         booth_addend = a_ext2;
      3'b100:         booth_addend = 34'd0 - a_ext2;
      3'b101, 3'b110: booth_addend = 34'd0 - a_ext;
      default:        booth_addend = '0;
    endcase
  end

  assign mul_sum   = {{2{acc_reg[64]}}, acc_reg[64:33]} + booth_addend;
  assign mult_step = {mul_sum, acc_reg[32:3], acc_reg[2]};
  assign mult_prod = mult_step[64:1];
`else
  // acc = {spare, hi[31:0], multiplier/low product[31:0]}; unsigned magnitudes.
  logic [32:0] mul_sum;
  logic [63:0] mul_mag;
  assign mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opd_reg} : 33'd0);
  assign mult_step = {1'b0, mul_sum, acc_reg[31:1]};
  assign mul_mag   = mult_step[63:0];
  assign mult_prod = neg_reg ? (~mul_mag + 64'd1) : mul_mag;
`endif

  // ---------------- divide step ----------------
  // acc = {signed partial remainder[32:0], dividend/quotient[31:0]}.
  logic [33:0] div_shift, div_rem;
  assign div_shift = {acc_reg[64:32], acc_reg[31]};
  assign div_rem   = acc_reg[64] ? (div_shift + {2'b00, opd_reg})
                                 : (div_shift - {2'b00, opd_reg});
  assign div_step  = {div_rem[32:0], acc_reg[30:0], ~div_rem[33]};
  assign div_q     = div_step[31:0];

  // ---------------- datapath registers ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_reg <= '0;
      opd_reg <= '0;
      neg_reg <= 1'b0;
    end else if (start_mult) begin
`ifdef MULTDIV_BOOTH4_EN
      acc_reg <= {32'd0, bus.data_operandB, 1'b0};
      opd_reg <= bus.data_operandA;
`else
      acc_reg <= {33'd0, abs32(bus.data_operandB)};
      opd_reg <= abs32(bus.data_operandA);
`endif
      neg_reg <= bus.data_operandA[31] ^ bus.data_operandB[31];
    end else if (start_div) begin
      acc_reg <= {33'd0, abs32(bus.data_operandA)};
      opd_reg <= abs32(bus.data_operandB);
      neg_reg <= bus.data_operandA[31] ^ bus.data_operandB[31];
    end else if (state_reg == MULT) begin
      acc_reg <= mult_step;
    end else if (state_reg == DIV) begin
      acc_reg <= div_step;
    end
  end

  // Results are loaded on the edge that enters DONE and then held.
  always_ff @(posedge clock) begin
    if (!reset) begin
      result_reg <= '0;
      exc_reg    <= 1'b0;
    end else if (div_by_zero) begin
      result_reg <= '0;
      exc_reg    <= 1'b1;
    end else if (finish_mult) begin
      result_reg <= mult_prod[31:0];
      // Overflow unless bits 63..31 are all equal (a pure sign extension).
      exc_reg    <= ~((&mult_prod[63:31]) | ~(|mult_prod[63:31]));
    end else if (finish_div) begin
      result_reg <= neg_reg ? (~div_q + 32'd1) : div_q;
      // A positive quotient with bit 31 set only arises from INT_MIN / -1.
      exc_reg    <= div_q[31] & ~neg_reg;
    end
  end

  assign bus.data_result    = result_reg;
  assign bus.data_exception = exc_reg;
  assign bus.data_resultRDY = rdy;
endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv -- self-checking bench for multdiv (radix-2 build by default,
// Booth latency expected when MULTDIV_BOOTH4_EN is defined).
module tb_multdiv;
  import multdiv_pkg::*;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MULT_LAT = 17;
`else
  localparam int MULT_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multdiv_if #(.WIDTH(32)) bus ();

  multdiv #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model(input bit mult, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic exc, output int lat);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (mult) begin
      r   = sa * sb;
      res = r[31:0];
      exc = (r != longint'($signed(r[31:0])));
      lat = MULT_LAT;
    end else if (sb == 0) begin
      res = 32'd0;
      exc = 1'b1;
      lat = 1;
    end else begin
      r   = sa / sb;
      res = r[31:0];
      exc = (r > 64'sd2147483647);
      lat = DIV_LAT;
    end
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h8000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'd0;
      3:       v = 32'h7FFF_FFFF;
      4, 5:    v = 32'($urandom_range(0, 200)) - 32'd100;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Drive a start for the current cycle; returns #1 after the sampling edge.
  task automatic start_op(input bit mult, input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT     = mult;
    bus.ctrl_DIV      = ~mult;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock); #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // Cycles after the start cycle until ready is seen (-1 on timeout).
  task automatic wait_rdy(input int limit, output int lat, output logic [31:0] res, output logic exc);
    lat = 1;
    while (bus.data_resultRDY !== 1'b1 && lat < limit) begin
      @(posedge clock); #1;
      lat++;
    end
    if (bus.data_resultRDY !== 1'b1) lat = -1;
    res = bus.data_result;
    exc = bus.data_exception;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int seen;
    reset = 1'b0;
    bus.ctrl_MULT = 1'b1;
    bus.ctrl_DIV  = 1'b0;
    bus.data_operandA = 32'd7;
    bus.data_operandB = 32'd3;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (bus.data_resultRDY !== 1'b0 || bus.data_result !== 32'd0 || bus.data_exception !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b result=%h exc=%b, required 0 00000000 0",
               bus.data_resultRDY, bus.data_result, bus.data_exception);
    end
    reset = 1'b1;
    bus.ctrl_MULT = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_start_ignored: %0d ready pulses, required 0", seen);
    end
    checks++;
    if (bus.data_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_result_hold: result=%h, required 00000000", bus.data_result);
    end
  endtask

  typedef struct {bit mult; logic [31:0] a; logic [31:0] b;} op_t;

  task automatic test_directed();
    op_t ops[10];
    logic [31:0] exp_res, res;
    logic exp_exc, exc;
    int exp_lat, lat;
    ops[0] = '{1'b1, 32'd7, 32'hFFFF_FFFD};
    ops[1] = '{1'b1, 32'h0001_0000, 32'h0001_0000};
    ops[2] = '{1'b0, 32'hFFFF_FFF9, 32'd2};
    ops[3] = '{1'b0, 32'd5, 32'd0};
    ops[4] = '{1'b0, INT_MIN, 32'hFFFF_FFFF};
    ops[5] = '{1'b0, INT_MIN, 32'd1};
    ops[6] = '{1'b1, INT_MIN, INT_MIN};
    ops[7] = '{1'b1, INT_MIN, 32'hFFFF_FFFF};
    ops[8] = '{1'b0, 32'd7, 32'hFFFF_FFF9};
    ops[9] = '{1'b0, 32'd3, 32'd7};
    foreach (ops[i]) begin
      model(ops[i].mult, ops[i].a, ops[i].b, exp_res, exp_exc, exp_lat);
      start_op(ops[i].mult, ops[i].a, ops[i].b);
      wait_rdy(60, lat, res, exc);
      $display("directed %s a=%h b=%h result=%h exc=%b lat=%0d",
               ops[i].mult ? "MUL" : "DIV", ops[i].a, ops[i].b, res, exc, lat);
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, exp_lat);
      end
      checks++;
      if (res !== exp_res || exc !== exp_exc) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h/%b, required %h/%b", i, res, exc, exp_res, exp_exc);
      end
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (bus.data_resultRDY !== 1'b0 || bus.data_result !== exp_res || bus.data_exception !== exp_exc) begin
        errors++;
        $display("FAIL directed_hold[%0d]: rdy=%b result=%h exc=%b, required 0 %h %b",
                 i, bus.data_resultRDY, bus.data_result, bus.data_exception, exp_res, exp_exc);
      end
    end
  endtask

  task automatic test_random();
    bit mult;
    logic [31:0] a, b, exp_res, res;
    logic exp_exc, exc;
    int exp_lat, lat;
    for (int i = 0; i < 40; i++) begin
      mult = 1'($urandom_range(0, 1));
      a = rnd_operand();
      b = rnd_operand();
      model(mult, a, b, exp_res, exp_exc, exp_lat);
      start_op(mult, a, b);
      wait_rdy(60, lat, res, exc);
      $display("random %s a=%h b=%h result=%h exc=%b lat=%0d", mult ? "MUL" : "DIV", a, b, res, exc, lat);
      checks++;
      if (lat != exp_lat || res !== exp_res || exc !== exp_exc) begin
        errors++;
        $display("FAIL random[%0d]: got lat=%0d %h/%b, required lat=%0d %h/%b",
                 i, lat, res, exc, exp_lat, exp_res, exp_exc);
      end
      @(posedge clock); #1;
      checks++;
      if (bus.data_resultRDY !== 1'b0) begin
        errors++;
        $display("FAIL random_pulse[%0d]: rdy=%b one cycle after ready, required 0", i, bus.data_resultRDY);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit mult;
    logic [31:0] a, b, exp_res, res;
    logic exp_exc, exc;
    int exp_lat, lat;
    mult = 1'b1;
    a = 32'd11;
    b = 32'd13;
    for (int i = 0; i < 6; i++) begin
      model(mult, a, b, exp_res, exp_exc, exp_lat);
      start_op(mult, a, b);
      wait_rdy(60, lat, res, exc);
      $display("b2b %s a=%h b=%h result=%h exc=%b lat=%0d", mult ? "MUL" : "DIV", a, b, res, exc, lat);
      checks++;
      if (lat != exp_lat || res !== exp_res || exc !== exp_exc) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got lat=%0d %h/%b, required lat=%0d %h/%b",
                 i, lat, res, exc, exp_lat, exp_res, exp_exc);
      end
      // Next start is driven during the DONE cycle itself.
      mult = 1'($urandom_range(0, 1));
      a = rnd_operand();
      b = rnd_operand();
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_abort();
    bit m1, m2;
    logic [31:0] a1, b1, a2, b2, exp_res, res;
    logic exp_exc, exc;
    int exp_lat, lat, off, early;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        m1 = 1'b0; a1 = 32'd1000; b1 = 32'd3;
        m2 = 1'b1; a2 = 32'd6;    b2 = 32'd7;
        off = 10;
      end else begin
        m1 = 1'($urandom_range(0, 1)); a1 = rnd_operand(); b1 = rnd_operand();
        if (b1 == 32'd0) b1 = 32'd5;
        m2 = 1'($urandom_range(0, 1)); a2 = rnd_operand(); b2 = rnd_operand();
        off = $urandom_range(2, 15);
      end
      model(m2, a2, b2, exp_res, exp_exc, exp_lat);
      start_op(m1, a1, b1);
      early = 0;
      for (int k = 1; k < off; k++) begin
        if (bus.data_resultRDY === 1'b1) early++;
        @(posedge clock); #1;
      end
      if (bus.data_resultRDY === 1'b1) early++;
      start_op(m2, a2, b2);
      wait_rdy(60, lat, res, exc);
      $display("abort off=%0d then %s a=%h b=%h result=%h exc=%b lat=%0d",
               off, m2 ? "MUL" : "DIV", a2, b2, res, exc, lat);
      checks++;
      if (early != 0) begin
        errors++;
        $display("FAIL abort_no_ready[%0d]: %0d pulses from aborted op, required 0", i, early);
      end
      checks++;
      if (lat != exp_lat || res !== exp_res || exc !== exp_exc) begin
        errors++;
        $display("FAIL abort_restart[%0d]: got lat=%0d %h/%b, required lat=%0d %h/%b",
                 i, lat, res, exc, exp_lat, exp_res, exp_exc);
      end
      repeat (2) @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic exc;
    int lat, seen, bad;
    start_op(1'b1, 32'd6, 32'd7);
    wait_rdy(60, lat, res, exc);
    checks++;
    if (res !== 32'd42 || exc !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pre: got %h/%b, required 0000002a/0", res, exc);
    end
    @(posedge clock); #1;
    start_op(1'b1, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0;             // low during cycle N+5
    @(posedge clock); #1;
    reset = 1'b1;
    checks++;
    if (bus.data_resultRDY !== 1'b0 || bus.data_result !== 32'd0 || bus.data_exception !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: rdy=%b result=%h exc=%b, required 0 00000000 0",
               bus.data_resultRDY, bus.data_result, bus.data_exception);
    end
    seen = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY === 1'b1) seen++;
      if (bus.data_result !== 32'd0) bad++;
    end
    checks++;
    if (seen != 0 || bad != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d pulses, %0d nonzero results, required 0/0", seen, bad);
    end
    start_op(1'b0, 32'd100, 32'hFFFF_FFF9);
    wait_rdy(60, lat, res, exc);
    $display("reset_mid restart DIV a=00000064 b=fffffff9 result=%h exc=%b lat=%0d", res, exc, lat);
    checks++;
    if (lat != DIV_LAT || res !== 32'hFFFF_FFF2 || exc !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_restart: got lat=%0d %h/%b, required lat=%0d fffffff2/0",
               lat, res, exc, DIV_LAT);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
